// File: rtl/fft_frame_capture_pkg.sv
// Shared types and helpers for the FFT frame capture sink.
// Includes the capture FSM state encoding and the readback word-address width.
package fft_frame_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } cap_state_e;

  // Word address covers RE and IM of every sample: 2*NFFT words.
  function automatic int word_addr_w(input int nfft);
    return $clog2(2 * nfft);
  endfunction

endpackage

// File: rtl/fft_frame_capture_bank_ram.sv
// One capture bank: NFFT entries of {IM,RE}, written a whole beat at a time,
// read asynchronously as DATA_W words (even address = RE, odd = IM).
module fft_frame_capture_bank_ram
  import fft_frame_capture_pkg::*;
#(
  parameter int NFFT   = 8,
  parameter int DATA_W = 32
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(NFFT)-1:0]        waddr,
  input  logic [2*DATA_W-1:0]            wdata,
  input  logic [word_addr_w(NFFT)-1:0]   raddr,
  output logic [DATA_W-1:0]              rdata
);

  localparam int AW = word_addr_w(NFFT);

  logic [2*DATA_W-1:0] mem_q [NFFT];
  logic [2*DATA_W-1:0] entry;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign entry = mem_q[raddr[AW-1:1]];
  assign rdata = raddr[0] ? entry[2*DATA_W-1:DATA_W] : entry[DATA_W-1:0];

endmodule

// File: rtl/fft_frame_capture.sv
// Double-buffered AXI-Stream sink for FFT frames: fills one bank while the host
// reads the other, commits only full frames and flags tlast framing errors.
module fft_frame_capture
  import fft_frame_capture_pkg::*;
#(
  parameter int NFFT   = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  output logic                          s_tready,
  input  logic                          s_tvalid,
  input  logic                          s_tlast,
  input  logic [2*DATA_W-1:0]           s_tdata,
  input  logic                          rd_bank,
  input  logic [word_addr_w(NFFT)-1:0]  rAddr,
  output logic [DATA_W-1:0]             rData,
  input  logic                          rd_release,
  output logic [1:0]                    bank_valid,
  output logic                          received,
  output logic                          frame_err,
  input  logic                          err_clr,
  output logic [CNT_W-1:0]              frame_count
);

  localparam int IDX_W = $clog2(NFFT);

  cap_state_e       state_q, state_d;
  logic             wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       bank_valid_q, bank_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;
  logic             beat;
  logic             we;
  logic             err_set;

  assign s_tready = (state_q == ST_RECV) || (state_q == ST_DRAIN);
  assign beat     = s_tvalid && s_tready;

  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    idx_d         = idx_q;
    bank_valid_d  = bank_valid_q;
    frame_count_d = frame_count_q;
    we            = 1'b0;
    err_set       = 1'b0;

    if (rd_release) begin
      bank_valid_d[rd_bank] = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!bank_valid_q[wr_bank_q]) begin
          state_d = ST_RECV;
          idx_d   = '0;
        end
      end
      ST_RECV: begin
        if (beat) begin
          we = 1'b1;
          if (idx_q == IDX_W'(NFFT - 1)) begin
            idx_d = '0;
            if (s_tlast) begin
              state_d = ST_COMMIT;
            end else begin
              err_set = 1'b1;
              state_d = ST_DRAIN;
            end
          end else if (s_tlast) begin
            // Short frame: drop it and refill the same bank.
            err_set = 1'b1;
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (beat && s_tlast) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        bank_valid_d[wr_bank_q] = 1'b1;
        frame_count_d           = frame_count_q + CNT_W'(1);
        wr_bank_d               = ~wr_bank_q;
        state_d                 = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    frame_err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      wr_bank_q     <= 1'b0;
      idx_q         <= '0;
      bank_valid_q  <= 2'b00;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      idx_q         <= idx_d;
      bank_valid_q  <= bank_valid_d;
      frame_err_q   <= frame_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  // The committing bank is reported valid already during the COMMIT cycle.
  assign bank_valid  = bank_valid_q |
                       ((state_q == ST_COMMIT) ? (2'b01 << wr_bank_q) : 2'b00);
  assign received    = (state_q == ST_COMMIT);
  assign frame_err   = frame_err_q;
  assign frame_count = frame_count_q;

  logic [DATA_W-1:0] bank_rdata [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      fft_frame_capture_bank_ram #(
        .NFFT   (NFFT),
        .DATA_W (DATA_W)
      ) u_ram (
        .clk   (clk),
        .we    (we && (wr_bank_q == gi[0])),
        .waddr (idx_q),
        .wdata (s_tdata),
        .raddr (rAddr),
        .rdata (bank_rdata[gi])
      );
    end
  endgenerate

  assign rData = bank_rdata[rd_bank];

endmodule
